// File: rtl/tx_serial_framer.sv
// rtl/tx_serial_framer.sv - 4-deep FIFO feeding a start/7-data/parity/stop serial framer.
// Optional macro TX_PARITY_INJECT_EN adds parity_inject to invert P of a frame at pop time.
module tx_serial_framer (
    input  logic       clk,
    input  logic       rstn,
`ifdef TX_PARITY_INJECT_EN
    input  logic       parity_inject,
`endif
    input  logic [6:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] fifo_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic       par_q;
    logic       push, pop, line_bit, inject;

    // Flow control looks only at registered occupancy, never at valid_in.
    assign ready_out  = (count != 3'd4);
    assign push       = valid_in && ready_out;
    assign fifo_count = count;
    assign busy       = (state_q != IDLE);

`ifdef TX_PARITY_INJECT_EN
    assign inject = parity_inject;
`else
    assign inject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        line_bit = 1'b1;
        case (state_q)
            IDLE: begin
                if (count != 3'd0) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                line_bit = 1'b0;
                state_d  = DATA;
            end
            DATA: begin
                line_bit = shift_reg[bit_cnt];
                if (bit_cnt == 3'd6) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                line_bit = par_q;
                state_d  = STOP;
            end
            STOP: begin
                // Back-to-back frames: pop straight from STOP to avoid an idle bit.
                if (count != 3'd0) begin
                    state_d = START;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            par_q      <= 1'b0;
            serial_out <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            serial_out <= line_bit;
            frame_done <= (state_q == STOP);
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                par_q     <= (^fifo_mem[rd_ptr]) ^ inject;
            end
            if (state_q == DATA && bit_cnt != 3'd6) begin
                bit_cnt <= bit_cnt + 3'd1;
            end else begin
                bit_cnt <= 3'd0;
            end
        end
    end

endmodule
